fb_port_scheduler: RTL and testbench

Double-buffered frame-buffer port scheduler. It shares one single-port BRAM (two 480x272 RGB565 banks) between the LCD scan-out reader and the image-filter engine, which reads and writes through a valid/ready handshake. LCD reads always win their slot. The filter always targets the back bank. Bank swaps are deferred to the start of LCD vertical sync so the display never tears. The block sits between the LCD timing generator, the filter engine and the BRAM primitive.

---
 rtl/fb_port_scheduler.sv | 128 ++++++++++++
 tb/tb_fb_port_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_scheduler.sv
// Single-port frame-buffer scheduler: LCD scan-out reads take priority over filter traffic,
// and the filter always works on the back bank. Bank swaps wait for the falling edge of LCD vsync.
module fb_port_scheduler #(
    parameter int ADDR_W       = 17,
    parameter int FRAME_PIXELS = 130560,
    parameter int BRAM_LAT     = 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iLcdEn,
    input  logic [ADDR_W-1:0] iLcdAddr,
    input  logic              iLcdVSync,
    output logic [15:0]       oLcdData,
    input  logic              iReqValid,
    input  logic              iReqWe,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [15:0]       iReqWData,
    output logic              oReqReady,
    output logic              oRspValid,
    output logic [15:0]       oRspData,
    input  logic              iSwapReq,
    output logic              oSwapPending,
    output logic              oSwapDone,
    output logic              oDispBank,
    output logic              oAddrErr,
    output logic              oBramEn,
    output logic              oBramWe,
    output logic [ADDR_W:0]   oBramAddr,
    output logic [15:0]       oBramWData,
    input  logic [15:0]       iBramRData
);

    localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_PIXELS);

    typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

    swap_state_t        state;
    logic               vsync_p0;
    logic               vsync_p1;
    logic [BRAM_LAT:0]  lcd_vld_p;
    logic [BRAM_LAT:0]  rd_vld_p;
    logic [BRAM_LAT:0]  rd_err_p;
    logic               vsync_fall;
    logic               req_fire;
    logic               addr_bad;

    assign vsync_fall = vsync_p1 & ~vsync_p0;
    assign oReqReady  = iRst_n & ~iLcdEn & ~oSwapPending;
    assign req_fire   = iReqValid & oReqReady;
    assign addr_bad   = (iReqAddr >= FRAME_LIM);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state        <= S_IDLE;
            vsync_p0     <= 1'b0;
            vsync_p1     <= 1'b0;
            oSwapPending <= 1'b0;
            oSwapDone    <= 1'b0;
            oDispBank    <= 1'b0;
            oAddrErr     <= 1'b0;
            oBramEn      <= 1'b0;
            oBramWe      <= 1'b0;
            oBramAddr    <= '0;
            oBramWData   <= '0;
            lcd_vld_p    <= '0;
            rd_vld_p     <= '0;
            rd_err_p     <= '0;
            oLcdData     <= '0;
            oRspValid    <= 1'b0;
            oRspData     <= '0;
        end else begin
            vsync_p0  <= iLcdVSync;
            vsync_p1  <= vsync_p0;
            oSwapDone <= 1'b0;

            // Swap control: a request coinciding with the vsync fall toggles without pending
            case (state)
                S_IDLE: begin
                    if (iSwapReq) begin
                        if (vsync_fall) begin
                            oDispBank <= ~oDispBank;
                            oSwapDone <= 1'b1;
                        end else begin
                            state        <= S_PENDING;
                            oSwapPending <= 1'b1;
                        end
                    end
                end
                S_PENDING: begin
                    if (vsync_fall) begin
                        oDispBank    <= ~oDispBank;
                        oSwapDone    <= 1'b1;
                        state        <= S_IDLE;
                        oSwapPending <= 1'b0;
                    end
                end
            endcase

            // Issue stage: address and data hold on idle or rejected cycles
            oBramEn <= 1'b0;
            oBramWe <= 1'b0;
            if (iLcdEn) begin
                oBramEn   <= 1'b1;
                oBramAddr <= {oDispBank, iLcdAddr};
            end else if (req_fire && !addr_bad) begin
                oBramEn   <= 1'b1;
                oBramWe   <= iReqWe;
                oBramAddr <= {~oDispBank, iReqAddr};
                if (iReqWe)
                    oBramWData <= iReqWData;
            end
            if (req_fire && addr_bad)
                oAddrErr <= 1'b1;

            // Return stage: one slot per cycle, so LCD and filter returns never overlap
            lcd_vld_p <= {lcd_vld_p[BRAM_LAT-1:0], iLcdEn};
            rd_vld_p  <= {rd_vld_p[BRAM_LAT-1:0], req_fire & ~iReqWe};
            rd_err_p  <= {rd_err_p[BRAM_LAT-1:0], addr_bad};

            if (lcd_vld_p[BRAM_LAT])
                oLcdData <= iBramRData;
            oRspValid <= rd_vld_p[BRAM_LAT];
            if (rd_vld_p[BRAM_LAT])
                oRspData <= rd_err_p[BRAM_LAT] ? 16'h0000 : iBramRData;
        end
    end

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed bench for fb_port_scheduler with a one-cycle-latency BRAM read model.
module tb_fb_port_scheduler;

    localparam int ADDR_W = 17;

    logic              iClk;
    logic              iRst_n;
    logic              iLcdEn;
    logic [ADDR_W-1:0] iLcdAddr;
    logic              iLcdVSync;
    logic [15:0]       oLcdData;
    logic              iReqValid;
    logic              iReqWe;
    logic [ADDR_W-1:0] iReqAddr;
    logic [15:0]       iReqWData;
    logic              oReqReady;
    logic              oRspValid;
    logic [15:0]       oRspData;
    logic              iSwapReq;
    logic              oSwapPending;
    logic              oSwapDone;
    logic              oDispBank;
    logic              oAddrErr;
    logic              oBramEn;
    logic              oBramWe;
    logic [ADDR_W:0]   oBramAddr;
    logic [15:0]       oBramWData;
    logic [15:0]       iBramRData;

    int errors = 0;
    int checks = 0;

    fb_port_scheduler #(.ADDR_W(ADDR_W), .FRAME_PIXELS(130560), .BRAM_LAT(1)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iLcdEn(iLcdEn), .iLcdAddr(iLcdAddr), .iLcdVSync(iLcdVSync), .oLcdData(oLcdData),
        .iReqValid(iReqValid), .iReqWe(iReqWe), .iReqAddr(iReqAddr), .iReqWData(iReqWData),
        .oReqReady(oReqReady), .oRspValid(oRspValid), .oRspData(oRspData),
        .iSwapReq(iSwapReq), .oSwapPending(oSwapPending), .oSwapDone(oSwapDone),
        .oDispBank(oDispBank), .oAddrErr(oAddrErr),
        .oBramEn(oBramEn), .oBramWe(oBramWe), .oBramAddr(oBramAddr),
        .oBramWData(oBramWData), .iBramRData(iBramRData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [15:0] bram_word(input logic [ADDR_W:0] a);
        case (a)
            18'h00005: bram_word = 16'h1234;
            18'h20064: bram_word = 16'hBEEF;
            18'h00064: bram_word = 16'h5A5A;
            default:   bram_word = 16'h0000;
        endcase
    endfunction

    always @(posedge iClk) begin
        if (oBramEn && !oBramWe)
            iBramRData <= bram_word(oBramAddr);
    end

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic swap_via_vsync;
        iLcdVSync = 1'b1; tick(); tick();
        iSwapReq = 1'b1; tick();
        iSwapReq = 1'b0; iLcdVSync = 1'b0; tick(); tick();
        iLcdVSync = 1'b1;
    endtask

    task automatic test_reset;
        iRst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({oLcdData, oRspValid, oRspData, oSwapPending, oSwapDone, oDispBank, oAddrErr,
             oBramEn, oBramWe, oBramAddr, oBramWData, oReqReady} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got lcd=%h rsp=%b/%h pend=%b done=%b bank=%b err=%b en=%b we=%b addr=%h wd=%h rdy=%b, required all 0",
                     oLcdData, oRspValid, oRspData, oSwapPending, oSwapDone, oDispBank, oAddrErr,
                     oBramEn, oBramWe, oBramAddr, oBramWData, oReqReady);
        end
        iRst_n = 1'b1;
        #1;
        checks++;
        if (oReqReady !== 1'b1) begin
            errors++; $display("FAIL idle_ready: got %b required 1", oReqReady);
        end
        tick();
        checks++;
        if ({oBramEn, oDispBank, oLcdData, oSwapDone} !== '0) begin
            errors++; $display("FAIL idle_after_reset: got en=%b bank=%b lcd=%h done=%b required 0",
                               oBramEn, oDispBank, oLcdData, oSwapDone);
        end
    endtask

    task automatic test_lcd_read;
        iLcdEn = 1'b1; iLcdAddr = 17'd5;
        #1;
        checks++;
        if (oReqReady !== 1'b0) begin
            errors++; $display("FAIL lcd_blocks_ready: got %b required 0", oReqReady);
        end
        tick();
        iLcdEn = 1'b0;
        checks++;
        if (oBramEn !== 1'b1 || oBramWe !== 1'b0 || oBramAddr !== 18'h00005) begin
            errors++; $display("FAIL lcd_issue: got en=%b we=%b addr=%h required 1 0 00005",
                               oBramEn, oBramWe, oBramAddr);
        end
        tick();
        checks++;
        if (oLcdData !== 16'h0000) begin
            errors++; $display("FAIL lcd_early: got %h required 0000", oLcdData);
        end
        tick();
        checks++;
        if (oLcdData !== 16'h1234) begin
            errors++; $display("FAIL lcd_data: got %h required 1234", oLcdData);
        end
        tick(); tick();
        checks++;
        if (oLcdData !== 16'h1234 || oRspValid !== 1'b0) begin
            errors++; $display("FAIL lcd_hold: got %h rsp=%b required 1234 rsp=0", oLcdData, oRspValid);
        end
    endtask

    task automatic test_collision;
        iLcdEn = 1'b1; iLcdAddr = 17'd9;
        iReqValid = 1'b1; iReqWe = 1'b1; iReqAddr = 17'd7; iReqWData = 16'hA5A5;
        #1;
        checks++;
        if (oReqReady !== 1'b0) begin
            errors++; $display("FAIL collide_ready: got %b required 0", oReqReady);
        end
        tick();
        iLcdEn = 1'b0;
        checks++;
        if (oBramEn !== 1'b1 || oBramWe !== 1'b0 || oBramAddr !== 18'h00009) begin
            errors++; $display("FAIL collide_lcd_first: got en=%b we=%b addr=%h required 1 0 00009",
                               oBramEn, oBramWe, oBramAddr);
        end
        #1;
        checks++;
        if (oReqReady !== 1'b1) begin
            errors++; $display("FAIL collide_ready_next: got %b required 1", oReqReady);
        end
        tick();
        iReqValid = 1'b0;
        checks++;
        if (oBramEn !== 1'b1 || oBramWe !== 1'b1 || oBramAddr !== 18'h20007 || oBramWData !== 16'hA5A5) begin
            errors++; $display("FAIL collide_write: got en=%b we=%b addr=%h wd=%h required 1 1 20007 a5a5",
                               oBramEn, oBramWe, oBramAddr, oBramWData);
        end
        tick(); tick(); tick();
        checks++;
        if (oRspValid !== 1'b0) begin
            errors++; $display("FAIL write_no_rsp: got %b required 0", oRspValid);
        end
    endtask

    task automatic test_back_to_back;
        iReqValid = 1'b1; iReqWe = 1'b1; iReqAddr = 17'd10; iReqWData = 16'h0001;
        tick();
        checks++;
        if (oBramEn !== 1'b1 || oBramAddr !== 18'h2000A || oBramWData !== 16'h0001) begin
            errors++; $display("FAIL b2b_first: got en=%b addr=%h wd=%h required 1 2000a 0001",
                               oBramEn, oBramAddr, oBramWData);
        end
        iReqAddr = 17'd11; iReqWData = 16'h0002; iLcdEn = 1'b1; iLcdAddr = 17'd20;
        tick();
        iLcdEn = 1'b0;
        checks++;
        if (oBramWe !== 1'b0 || oBramAddr !== 18'h00014 || oBramWData !== 16'h0001) begin
            errors++; $display("FAIL b2b_lcd_slot: got we=%b addr=%h wd=%h required 0 00014 0001",
                               oBramWe, oBramAddr, oBramWData);
        end
        tick();
        checks++;
        if (oBramWe !== 1'b1 || oBramAddr !== 18'h2000B || oBramWData !== 16'h0002) begin
            errors++; $display("FAIL b2b_second: got we=%b addr=%h wd=%h required 1 2000b 0002",
                               oBramWe, oBramAddr, oBramWData);
        end
        iReqAddr = 17'd12; iReqWData = 16'h0003;
        tick();
        iReqValid = 1'b0;
        checks++;
        if (oBramWe !== 1'b1 || oBramAddr !== 18'h2000C || oBramWData !== 16'h0003) begin
            errors++; $display("FAIL b2b_third: got we=%b addr=%h wd=%h required 1 2000c 0003",
                               oBramWe, oBramAddr, oBramWData);
        end
        tick();
        checks++;
        if (oBramEn !== 1'b0 || oBramWe !== 1'b0 || oBramAddr !== 18'h2000C || oBramWData !== 16'h0003) begin
            errors++; $display("FAIL idle_hold: got en=%b we=%b addr=%h wd=%h required 0 0 2000c 0003",
                               oBramEn, oBramWe, oBramAddr, oBramWData);
        end
    endtask

    task automatic test_filter_read;
        iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 17'd100;
        tick();
        iReqValid = 1'b0;
        checks++;
        if (oBramEn !== 1'b1 || oBramWe !== 1'b0 || oBramAddr !== 18'h20064) begin
            errors++; $display("FAIL rd_issue: got en=%b we=%b addr=%h required 1 0 20064",
                               oBramEn, oBramWe, oBramAddr);
        end
        tick();
        checks++;
        if (oRspValid !== 1'b0) begin
            errors++; $display("FAIL rd_early: got %b required 0", oRspValid);
        end
        tick();
        checks++;
        if (oRspValid !== 1'b1 || oRspData !== 16'hBEEF) begin
            errors++; $display("FAIL rd_rsp: got valid=%b data=%h required 1 beef", oRspValid, oRspData);
        end
        tick();
        checks++;
        if (oRspValid !== 1'b0) begin
            errors++; $display("FAIL rd_single: got %b required 0", oRspValid);
        end
    endtask

    task automatic test_addr_err;
        iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 17'd130560;
        #1;
        checks++;
        if (oReqReady !== 1'b1) begin
            errors++; $display("FAIL oor_ready: got %b required 1", oReqReady);
        end
        tick();
        iReqValid = 1'b0;
        checks++;
        if (oBramEn !== 1'b0 || oAddrErr !== 1'b1) begin
            errors++; $display("FAIL oor_issue: got en=%b err=%b required 0 1", oBramEn, oAddrErr);
        end
        tick(); tick();
        checks++;
        if (oRspValid !== 1'b1 || oRspData !== 16'h0000) begin
            errors++; $display("FAIL oor_rsp: got valid=%b data=%h required 1 0000", oRspValid, oRspData);
        end
        iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 17'd130559;
        tick();
        iReqValid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (oAddrErr !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b required 1", oAddrErr);
        end
    endtask

    task automatic test_swap;
        iSwapReq = 1'b1;
        tick();
        iSwapReq = 1'b0;
        #1;
        checks++;
        if (oSwapPending !== 1'b1 || oReqReady !== 1'b0 || oDispBank !== 1'b0) begin
            errors++; $display("FAIL swap_pending: got pend=%b rdy=%b bank=%b required 1 0 0",
                               oSwapPending, oReqReady, oDispBank);
        end
        tick();
        iSwapReq = 1'b1;
        tick();
        iSwapReq = 1'b0;
        tick();
        checks++;
        if (oSwapPending !== 1'b1 || oDispBank !== 1'b0 || oSwapDone !== 1'b0) begin
            errors++; $display("FAIL swap_second_req: got pend=%b bank=%b done=%b required 1 0 0",
                               oSwapPending, oDispBank, oSwapDone);
        end
        iLcdVSync = 1'b0;
        tick();
        checks++;
        if (oDispBank !== 1'b0 || oSwapDone !== 1'b0) begin
            errors++; $display("FAIL swap_too_early: got bank=%b done=%b required 0 0", oDispBank, oSwapDone);
        end
        tick();
        checks++;
        if (oDispBank !== 1'b1 || oSwapDone !== 1'b1 || oSwapPending !== 1'b0 || oReqReady !== 1'b1) begin
            errors++; $display("FAIL swap_take: got bank=%b done=%b pend=%b rdy=%b required 1 1 0 1",
                               oDispBank, oSwapDone, oSwapPending, oReqReady);
        end
        tick();
        checks++;
        if (oSwapDone !== 1'b0 || oDispBank !== 1'b1) begin
            errors++; $display("FAIL swap_done_pulse: got done=%b bank=%b required 0 1", oSwapDone, oDispBank);
        end
        iLcdEn = 1'b1; iLcdAddr = 17'd3;
        tick();
        iLcdEn = 1'b0;
        checks++;
        if (oBramAddr !== 18'h20003) begin
            errors++; $display("FAIL lcd_new_bank: got %h required 20003", oBramAddr);
        end
    endtask

    task automatic test_swap_coincident;
        iLcdVSync = 1'b1;
        tick(); tick();
        iLcdVSync = 1'b0;
        tick();
        iSwapReq = 1'b1;
        tick();
        iSwapReq = 1'b0;
        checks++;
        if (oDispBank !== 1'b0 || oSwapDone !== 1'b1 || oSwapPending !== 1'b0) begin
            errors++; $display("FAIL coincident_swap: got bank=%b done=%b pend=%b required 0 1 0",
                               oDispBank, oSwapDone, oSwapPending);
        end
        tick();
        checks++;
        if (oDispBank !== 1'b0 || oSwapDone !== 1'b0 || oSwapPending !== 1'b0) begin
            errors++; $display("FAIL coincident_after: got bank=%b done=%b pend=%b required 0 0 0",
                               oDispBank, oSwapDone, oSwapPending);
        end
        iLcdVSync = 1'b1;
    endtask

    task automatic test_reset_inflight;
        int rsp_seen;
        swap_via_vsync();
        checks++;
        if (oDispBank !== 1'b1) begin
            errors++; $display("FAIL pre_reset_bank: got %b required 1", oDispBank);
        end
        tick();
        iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 17'd100;
        tick();
        iReqValid = 1'b0;
        checks++;
        if (oBramEn !== 1'b1 || oBramAddr !== 18'h00064) begin
            errors++; $display("FAIL inflight_issue: got en=%b addr=%h required 1 00064", oBramEn, oBramAddr);
        end
        iRst_n = 1'b0;
        tick();
        iRst_n = 1'b1;
        checks++;
        if (oDispBank !== 1'b0 || oAddrErr !== 1'b0 || oBramEn !== 1'b0) begin
            errors++; $display("FAIL reset_clears: got bank=%b err=%b en=%b required 0 0 0",
                               oDispBank, oAddrErr, oBramEn);
        end
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (oRspValid === 1'b1) rsp_seen++;
            tick();
        end
        checks++;
        if (rsp_seen !== 0) begin
            errors++; $display("FAIL reset_drops_read: got %0d responses required 0", rsp_seen);
        end
    endtask

    initial begin
        iRst_n = 1'b0; iLcdEn = 1'b0; iLcdAddr = '0; iLcdVSync = 1'b1;
        iReqValid = 1'b0; iReqWe = 1'b0; iReqAddr = '0; iReqWData = '0;
        iSwapReq = 1'b0; iBramRData = '0;
        test_reset();
        test_lcd_read();
        test_collision();
        test_back_to_back();
        test_filter_read();
        test_addr_err();
        test_swap();
        test_swap_coincident();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
